adc_scan_controller: RTL and testbench

//  SPI master frame engine for an 8-channel, 12-bit serial ADC: drives CSN and DIN, captures DOUT.

---
 rtl/adc_scan_controller.sv | 115 +++++++++++
 tb/tb_adc_scan_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_controller.sv
// adc_scan_controller: SPI frame engine for a serial multi-channel ADC.
// Sends the control word on DIN, captures DOUT and presents {channel, data} on a valid/ready port.
module adc_scan_controller #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int ADDR_BITS   = 3,
    parameter int NUM_CH      = 8,
    parameter int IDLE_CYCLES = 1
) (
    input  logic                 SCLK,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic                 scanMode,
    input  logic [ADDR_BITS-1:0] chanSel,
    input  logic [NUM_CH-1:0]    chanMask,
    input  logic                 rangeSel,
    input  logic                 codingSel,
    input  logic                 DOUT,
    output logic                 CSN,
    output logic                 DIN,
    output logic [DATA_BITS-1:0] resultData,
    output logic [ADDR_BITS-1:0] resultChan,
    output logic                 resultValid,
    input  logic                 resultReady,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = 9 + ADDR_BITS;
    localparam int BW = $clog2(FRAME_BITS);
    localparam int GW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t                state, state_nx;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [FRAME_BITS-1:0] ctrl, ctrl_word;
    logic [FRAME_BITS-3:0] shift;
    logic [FRAME_BITS-2:0] word;
    logic [ADDR_BITS-1:0]  addr, addr_nx, scan_lo, scan_up;
    logic                  found_up, primed, frame_end, gap_end, entry;

    always_comb begin
        frame_end = state == FRAME && bit_cnt == BW'(FRAME_BITS - 1);
        gap_end   = state == GAP && gap_cnt == GW'(IDLE_CYCLES - 1);
        entry     = enable && (state == IDLE || gap_end);
        state_nx  = entry ? FRAME : frame_end ? GAP : gap_end ? IDLE : state;
        busy      = state != IDLE;
        word      = {shift, DOUT};
        scan_lo   = '0;
        scan_up   = '0;
        found_up  = 1'b0;
        // Descending walk leaves the lowest set bit overall and the lowest set bit above addr.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chanMask[i]) scan_lo = ADDR_BITS'(i);
            if (chanMask[i] && i > int'(addr)) begin
                scan_up  = ADDR_BITS'(i);
                found_up = 1'b1;
            end
        end
        addr_nx   = (!scanMode || chanMask == '0) ? chanSel :
                    (state == IDLE || !found_up) ? scan_lo : scan_up;
        ctrl_word = FRAME_BITS'({3'b100, addr_nx, 4'b1100, rangeSel, codingSel}) << (FRAME_BITS - CW);
    end

    always_ff @(posedge SCLK) begin
        if (!resetN) begin
            state       <= IDLE;
            CSN         <= 1'b1;
            DIN         <= 1'b0;
            resultData  <= '0;
            resultChan  <= '0;
            resultValid <= 1'b0;
            overrun     <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            primed      <= 1'b0;
            ctrl        <= '0;
            shift       <= '0;
            addr        <= '0;
        end else begin
            state <= state_nx;
            if (entry) begin
                CSN     <= 1'b0;
                bit_cnt <= '0;
                DIN     <= ctrl_word[FRAME_BITS-1];
                ctrl    <= ctrl_word << 1;
                addr    <= addr_nx;
                if (state == IDLE) primed <= 1'b0;
            end else if (state == FRAME) begin
                shift   <= {shift[FRAME_BITS-4:0], DOUT};
                DIN     <= frame_end ? 1'b0 : ctrl[FRAME_BITS-1];
                ctrl    <= ctrl << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (frame_end) begin
                    CSN     <= 1'b1;
                    gap_cnt <= '0;
                    primed  <= 1'b1;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            // A load on the same edge as an accept keeps valid high and is not an overrun.
            if (frame_end && primed) begin
                resultChan  <= word[FRAME_BITS-2 -: ADDR_BITS];
                resultData  <= word[FRAME_BITS-2-ADDR_BITS -: DATA_BITS];
                resultValid <= 1'b1;
                overrun     <= overrun | (resultValid & ~resultReady);
            end else begin
                if (resultValid && resultReady) resultValid <= 1'b0;
                if (gap_end && !enable) overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller: bench for adc_scan_controller with an ADC echo model,
// a frame-level reference model compared every cycle, and directed literal checks.
module tb_adc_scan_controller;
    localparam int FB = 16;
    localparam int IC = 1;

    logic        SCLK = 0;
    logic        resetN, enable, scanMode, rangeSel, codingSel, resultReady;
    logic [2:0]  chanSel;
    logic [7:0]  chanMask;
    logic        DOUT = 0;
    logic        CSN, DIN, resultValid, overrun, busy;
    logic [11:0] resultData;
    logic [2:0]  resultChan;

    adc_scan_controller dut (
        .SCLK(SCLK), .resetN(resetN), .enable(enable), .scanMode(scanMode),
        .chanSel(chanSel), .chanMask(chanMask), .rangeSel(rangeSel), .codingSel(codingSel),
        .DOUT(DOUT), .CSN(CSN), .DIN(DIN), .resultData(resultData), .resultChan(resultChan),
        .resultValid(resultValid), .resultReady(resultReady), .overrun(overrun), .busy(busy)
    );

    always #5 SCLK = ~SCLK;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC: captures the control word, returns {0, previous ADDR, value} in the next frame.
    logic [11:0] adc_val [8];
    logic [15:0] adc_cap;
    logic [2:0]  adc_prev = '0;
    int          adc_k = 0;
    int          cyc = 0;
    logic [15:0] cap_q[$];
    int          len_q[$];
    int          start_q[$];
    logic [14:0] res_q[$];
    wire  [15:0] adc_word = {1'b0, adc_prev, adc_val[adc_prev]};

    always @(posedge SCLK) begin
        cyc <= cyc + 1;
        if (CSN === 1'b0) begin
            adc_cap <= {adc_cap[14:0], DIN};
            adc_k   <= adc_k + 1;
            if (adc_k == 0) start_q.push_back(cyc);
        end else if (adc_k != 0) begin
            len_q.push_back(adc_k);
            adc_k <= 0;
            if (adc_k == 16) begin
                cap_q.push_back(adc_cap);
                adc_prev <= adc_cap[12:10];
            end
        end
        if (resetN && resultValid && resultReady) res_q.push_back({resultChan, resultData});
    end

    always @(negedge SCLK) DOUT <= (CSN === 1'b0 && adc_k < 16) ? adc_word[15-adc_k] : 1'b0;

    // Reference model: frame position, the address each frame carries, and the result it returns.
    function automatic logic [2:0] pick(input bit first, input logic [2:0] prev, input logic scan,
                                        input logic [7:0] mask, input logic [2:0] sel);
        if (!scan || mask == 0) return sel;
        if (first) begin
            for (int i = 0; i < 8; i++) if (mask[i]) return 3'(i);
        end
        for (int i = 1; i <= 8; i++) if (mask[(int'(prev) + i) % 8]) return 3'((int'(prev) + i) % 8);
        return sel;
    endfunction

    function automatic logic [15:0] cword(input logic [2:0] a, input logic r, input logic c);
        return {3'b100, a, 4'b1100, r, c, 4'b0000};
    endfunction

    int          m_pos = -1;
    logic        m_csn = 1, m_din = 0, m_valid = 0, m_ovr = 0, m_dummy = 1;
    logic [11:0] m_data = 0;
    logic [2:0]  m_chan = 0, m_addr = 0, m_prev = 0, m_next_addr;
    logic [15:0] m_word = 0, m_next_word;

    always_comb begin
        m_next_addr = pick(m_pos == -1, m_addr, scanMode, chanMask, chanSel);
        m_next_word = cword(m_next_addr, rangeSel, codingSel);
    end

    always @(posedge SCLK) begin
        if (!resetN) begin
            m_pos   <= -1;
            m_csn   <= 1;
            m_din   <= 0;
            m_valid <= 0;
            m_data  <= 0;
            m_chan  <= 0;
            m_ovr   <= 0;
        end else begin
            if (m_valid && resultReady) m_valid <= 0;
            if (m_pos == -1 || m_pos == FB + IC - 1) begin
                if (enable) begin
                    m_addr  <= m_next_addr;
                    m_word  <= m_next_word;
                    m_din   <= m_next_word[15];
                    m_csn   <= 0;
                    m_dummy <= m_pos == -1;
                    m_pos   <= 0;
                end else begin
                    m_pos <= -1;
                    if (m_pos != -1) m_ovr <= 0;
                end
            end else if (m_pos < FB - 1) begin
                m_din <= m_word[FB-2-m_pos];
                m_pos <= m_pos + 1;
            end else if (m_pos == FB - 1) begin
                m_csn  <= 1;
                m_din  <= 0;
                m_pos  <= m_pos + 1;
                m_prev <= m_addr;
                if (!m_dummy) begin
                    m_chan  <= m_prev;
                    m_data  <= adc_val[m_prev];
                    m_valid <= 1;
                    if (m_valid && !resultReady) m_ovr <= 1;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge SCLK) begin
        if (chk_on) begin
            chk("CSN", CSN, m_csn);
            chk("DIN", DIN, m_din);
            chk("busy", busy, m_pos != -1);
            chk("resultValid", resultValid, m_valid);
            chk("overrun", overrun, m_ovr);
            if (m_valid) begin
                chk("resultData", resultData, m_data);
                chk("resultChan", resultChan, m_chan);
            end
        end
    end

    task automatic wait_k(input int k);
        for (int n = 0; n < 200; n++) begin
            @(negedge SCLK);
            if (adc_k == k && CSN === (k == 16)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_k: bit %0d never reached", k);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge SCLK);
            if (busy === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy stuck at %b", busy);
    endtask

    initial begin
        logic [15:0] w;
        logic [2:0]  exp_addr [5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        logic [2:0]  exp_tag  [4] = '{3'd0, 3'd2, 3'd7, 3'd0};
        for (int c = 0; c < 8; c++) adc_val[c] = 12'(12'h123 + 12'h111 * c);
        adc_val[5] = 12'hA5C;
        resetN = 0; enable = 0; scanMode = 0; chanSel = 0; chanMask = 0;
        rangeSel = 0; codingSel = 0; resultReady = 1;
        @(negedge SCLK);
        chk_on = 1;
        @(negedge SCLK);
        chk("rst_CSN", CSN, 1);
        chk("rst_DIN", DIN, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resultValid, 0);
        chk("rst_data", resultData, 0);
        chk("rst_chan", resultChan, 0);
        chk("rst_overrun", overrun, 0);

        // T1: reset while bitCnt=7
        resetN = 1; chanSel = 5; rangeSel = 1; enable = 1;
        wait_k(7);
        resetN = 0;
        @(negedge SCLK);
        chk("t1_CSN", CSN, 1);
        chk("t1_busy", busy, 0);
        chk("t1_valid", resultValid, 0);
        resetN = 1;
        @(negedge SCLK);
        cap_q.delete(); len_q.delete(); start_q.delete(); res_q.delete();

        // T2/T3: single channel 5, echoed data A5C
        repeat (4) wait_k(16);
        chk("t2_frames", cap_q.size(), 3);
        for (int i = 0; i < cap_q.size(); i++) begin
            chk("t2_word", cap_q[i], 16'h9720);
            chk("t2_csn_low", len_q[i], 16);
        end
        for (int i = 0; i + 1 < start_q.size(); i++) chk("t2_period", start_q[i+1] - start_q[i], 17);
        chk("t3_results", res_q.size(), 2);
        if (res_q.size() > 0) chk("t3_first", res_q[0], {3'd5, 12'hA5C});
        chk("t3_valid_hi", resultValid, 1);
        chk("t3_chan", resultChan, 5);
        chk("t3_data", resultData, 12'hA5C);
        @(negedge SCLK);
        chk("t3_valid_pulse", resultValid, 0);

        // T6: enable dropped at bitCnt=3
        wait_k(3);
        enable = 0;
        res_q.delete();
        wait_k(16);
        chk("t6_valid", resultValid, 1);
        chk("t6_chan", resultChan, 5);
        chk("t6_data", resultData, 12'hA5C);
        @(negedge SCLK);
        chk("t6_busy", busy, 0);
        repeat (5) @(negedge SCLK);
        chk("t6_csn_high", CSN, 1);
        chk("t6_results", res_q.size(), 1);

        // T4: scan mask 1000_0101
        scanMode = 1; chanMask = 8'b1000_0101;
        cap_q.delete(); res_q.delete();
        enable = 1;
        repeat (5) wait_k(16);
        @(negedge SCLK);
        chk("t4_frames", cap_q.size(), 5);
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            w = cap_q[i];
            chk("t4_addr", w[12:10], exp_addr[i]);
        end
        chk("t4_results", res_q.size(), 4);
        for (int i = 0; i < 4 && i < res_q.size(); i++) chk("t4_tag", res_q[i][14:12], exp_tag[i]);
        if (res_q.size() > 2) chk("t4_ch7", res_q[2], {3'd7, 12'h89A});

        // T5a: two unaccepted results, then IDLE clears overrun
        wait_k(5);
        resultReady = 0;
        wait_k(16);
        chk("t5_ovr_first", overrun, 0);
        wait_k(16);
        chk("t5_ovr_set", overrun, 1);
        chk("t5_valid", resultValid, 1);
        chk("t5_chan", resultChan, 7);
        chk("t5_data", resultData, 12'h89A);
        enable = 0;
        wait_idle();
        chk("t5_idle_ovr", overrun, 0);
        chk("t5_idle_valid", resultValid, 1);
        resultReady = 1;
        @(negedge SCLK);
        chk("t5_drain", resultValid, 0);

        // T5b: ready raised exactly on a frame-end edge
        resultReady = 0; res_q.delete();
        enable = 1;
        wait_k(16);
        wait_k(16);
        chk("t5b_valid", resultValid, 1);
        chk("t5b_chan", resultChan, 0);
        wait_k(15);
        resultReady = 1;
        wait_k(16);
        chk("t5b_valid_kept", resultValid, 1);
        chk("t5b_no_ovr", overrun, 0);
        chk("t5b_chan2", resultChan, 2);
        chk("t5b_data2", resultData, 12'h345);
        chk("t5b_taken", res_q.size(), 1);
        @(negedge SCLK);
        chk("t5b_drain", resultValid, 0);

        enable = 0;
        wait_idle();
        repeat (2) @(negedge SCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
